// File: rtl/n3_ctrl.sv
// Control block for the n3 sigmoid datapath: coefficient table loading,
// credit-based sample issue, and a small result FIFO that absorbs datapath latency.
module n3_ctrl #(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_SEG    = 16,
    parameter int PIPE_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_cfg_start,
    input  logic                       i_cfg_valid,
    input  logic [2*BIT_WIDTH-1:0]     i_cfg_data,
    output logic                       o_cfg_ready,
    output logic                       o_cfg_done,
    input  logic                       i_x_valid,
    input  logic [BIT_WIDTH-1:0]       i_x,
    output logic                       o_x_ready,
    output logic [BIT_WIDTH-1:0]       o_n3_x,
    output logic [2*BIT_WIDTH-1:0]     o_n3_coef,
    output logic [$clog2(NUM_SEG)-1:0] o_n3_coef_addr,
    output logic                       o_n3_load_coef,
    input  logic [BIT_WIDTH-1:0]       i_n3_y,
    output logic                       o_y_valid,
    output logic [BIT_WIDTH-1:0]       o_y,
    input  logic                       i_y_ready
);
    localparam int AW = $clog2(NUM_SEG);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + PIPE_LAT + 1) + 1;

    localparam logic [1:0] ST_UNCFG = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]           state;
    logic [AW-1:0]        seg_cnt;
    logic [PIPE_LAT-1:0]  vld_p;
    logic [BIT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        fifo_cnt;
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        credit_used;
    logic                 coef_wr;
    logic                 x_hs;
    logic                 y_push;
    logic                 y_pop;

    // Samples issued to the datapath whose result has not yet landed in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + CW'(vld_p[i]);
        end
        credit_used = fifo_cnt + inflight;
    end

    always_comb begin
        o_cfg_ready    = (state == ST_LOAD);
        coef_wr        = o_cfg_ready & i_cfg_valid;
        o_n3_load_coef = coef_wr;
        o_n3_coef      = coef_wr ? i_cfg_data : '0;
        o_n3_coef_addr = coef_wr ? seg_cnt : '0;
        // A reload request withdraws readiness in the same cycle it is raised.
        o_cfg_done     = (state == ST_RUN) & ~i_cfg_start;
        o_x_ready      = o_cfg_done & (credit_used < CW'(FIFO_DEPTH));
        x_hs           = o_x_ready & i_x_valid;
        o_n3_x         = x_hs ? i_x : '0;
        y_push         = vld_p[PIPE_LAT-1];
        o_y_valid      = (fifo_cnt != '0);
        y_pop          = o_y_valid & i_y_ready;
        o_y            = o_y_valid ? fifo_mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_UNCFG;
            seg_cnt <= '0;
        end else begin
            case (state)
                ST_UNCFG: begin
                    if (i_cfg_start) begin
                        state   <= ST_LOAD;
                        seg_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (coef_wr) begin
                        seg_cnt <= seg_cnt + AW'(1);
                        if (seg_cnt == AW'(NUM_SEG - 1)) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_cfg_start) begin
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                    // Results still in flight must land before the table may change.
                    if (inflight == '0) begin
                        state   <= ST_LOAD;
                        seg_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Issue stage -> datapath result stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= x_hs;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (y_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (y_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({y_push, y_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (y_push) begin
            fifo_mem[wr_ptr] <= i_n3_y;
        end
    end

endmodule

// File: doc/n3_ctrl.md
N3_CTRL -- requirements
Module: n3_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, the data word width.
REQ-002 SHALL have parameter NUM_SEG, default 16, the number of coefficient entries.
REQ-003 SHALL have parameter PIPE_LAT, default 2, the number of cycles from o_n3_x to a valid i_n3_y.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the depth of the result FIFO (power of 2, at least PIPE_LAT).
REQ-005 Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- i_cfg_start  in  1  request to reload the coefficient table.
- i_cfg_valid  in  1  coefficient word valid.
- i_cfg_data  in  2*BIT_WIDTH  coefficient word {Ai,Bi}.
- o_cfg_ready  out  1  coefficient word accepted this cycle when high with i_cfg_valid.
- o_cfg_done  out  1  table loaded; unit usable.
- i_x_valid  in  1  input sample valid.
- i_x  in  BIT_WIDTH  input sample.
- o_x_ready  out  1  sample accepted when high with i_x_valid.
- o_n3_x  out  BIT_WIDTH  sample to the sigmoid datapath.
- o_n3_coef  out  2*BIT_WIDTH  coefficient write data.
- o_n3_coef_addr  out  log2(NUM_SEG)  coefficient write address.
- o_n3_load_coef  out  1  coefficient write enable.
- i_n3_y  in  BIT_WIDTH  datapath result.
- o_y_valid  out  1  result available.
- o_y  out  BIT_WIDTH  result.
- i_y_ready  in  1  consumer accepts the result.

Function
REQ-006 SHALL implement states UNCFG, LOAD, RUN and DRAIN.
REQ-007 UNCFG: i_cfg_start SHALL move to LOAD with the address counter at 0.
REQ-008 LOAD: o_cfg_ready=1; each i_cfg_valid&o_cfg_ready SHALL drive o_n3_load_coef=1, o_n3_coef=i_cfg_data and o_n3_coef_addr=counter in the same cycle (combinational), then increment the counter.
REQ-009 LOAD: the write at address NUM_SEG-1 SHALL move to RUN and set o_cfg_done=1 on the next cycle.
REQ-010 LOAD: i_cfg_start SHALL be ignored.
REQ-011 RUN: o_x_ready SHALL equal (fifo_count + inflight < FIFO_DEPTH), where inflight is the number of accepted samples not yet written to the FIFO.
REQ-012 RUN: a handshake SHALL drive o_n3_x=i_x in the same cycle and insert a 1 into a PIPE_LAT-deep valid shift register.
REQ-013 A valid bit exiting the shift register SHALL push i_n3_y into the FIFO in that cycle, i.e. PIPE_LAT cycles after acceptance.
REQ-014 RUN: i_cfg_start SHALL move to DRAIN, clear o_cfg_done and drop o_x_ready in the same cycle; an input handshake is not taken in that cycle.
REQ-015 DRAIN: o_x_ready=0; the block SHALL move to LOAD (counter=0) when inflight==0; the FIFO is not required to be empty.
REQ-016 Outside LOAD: o_cfg_ready=0 and o_n3_load_coef=0; i_cfg_valid SHALL be ignored.
REQ-017 Outside RUN: o_x_ready=0.
REQ-018 o_y_valid SHALL be (fifo_count != 0) and o_y the FIFO head; a pop occurs on o_y_valid&i_y_ready.
REQ-019 A push and a pop in the same cycle SHALL leave the count unchanged; a push while full cannot occur (credit rule); a pop while empty SHALL do nothing.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 The FIFO SHALL pop in every state.
REQ-022 o_n3_x SHALL be 0 when there is no handshake.
REQ-023 o_n3_coef and o_n3_coef_addr SHALL be 0 when there is no write.

Reset
REQ-024 rst_n=0 at a clock edge SHALL set state=UNCFG, counter=0, the valid shift register to 0, FIFO pointers and count to 0, and o_cfg_done=0.
REQ-025 After reset all outputs SHALL be 0.
REQ-026 Reset in the middle of LOAD SHALL leave the table considered invalid; a full reload through i_cfg_start is required before samples are accepted.
REQ-027 Reset in RUN SHALL discard in-flight samples and FIFO contents.

Verification
REQ-028 Reset, then pulse i_cfg_start and supply 16 words 0x0000_0000..0x000F_000F -> o_n3_load_coef for 16 cycles at addresses 0..15; o_cfg_done=1 one cycle after the last write.
REQ-029 Send i_x=0x1234 in RUN with i_y_ready=1 -> o_n3_x=0x1234 in the same cycle; the i_n3_y captured 2 cycles later appears on o_y with o_y_valid=1.
REQ-030 Hold i_y_ready=0 and stream samples -> exactly 4 are accepted; o_x_ready falls after the 4th; releasing i_y_ready returns results in order with none lost.
REQ-031 Assert i_cfg_start with 2 samples in flight -> o_x_ready=0 immediately; both results still enter the FIFO; LOAD is entered once inflight=0.
REQ-032 Drop rst_n after 7 of 16 coefficient words -> state UNCFG, o_cfg_done=0, o_x_ready=0; i_x_valid is not accepted until a fresh 16-word load completes.
REQ-033 A simultaneous push and pop with the FIFO holding 3 -> count stays 3; pointers wrap correctly across 10 or more transfers.
